// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control FSM for the iterative multiply/divide datapath
module multdiv_sequencer #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_fixup,
    output logic             dp_is_div,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_MULT = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] LAST_DIV  = CNT_W'(DIV_STEPS - 1);

    state_t           r_state;
    logic             r_mode;
    logic             r_exc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_start;
    logic             w_start_div;
    logic [CNT_W-1:0] w_last;

    // Reset wins over a coincident start; MULT wins over DIV when both pulse.
    assign w_start     = (ctrl_MULT | ctrl_DIV) & ~reset;
    assign w_start_div = ctrl_DIV & ~ctrl_MULT;
    assign w_last      = r_mode ? LAST_DIV : LAST_MULT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_exc   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_start) begin
            // A start in any state abandons whatever was in flight.
            r_mode <= w_start_div;
            r_cnt  <= '0;
            if (w_start_div && divisor_zero) begin
                r_state <= S_DONE;
                r_exc   <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_exc   <= 1'b0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt == w_last) begin
                        r_cnt   <= '0;
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_exc   <= ~r_mode & mult_ovf;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dp_load        = w_start;
    assign dp_step        = (r_state == S_RUN) & ~w_start;
    assign dp_fixup       = (r_state == S_FIXUP) & ~w_start;
    assign dp_is_div      = w_start ? w_start_div : r_mode;
    assign step_cnt       = r_cnt;
    assign busy           = (r_state != S_IDLE);
    // The completed op still reports in its DONE cycle even if a new start arrives.
    assign data_resultRDY = (r_state == S_DONE);
    assign data_exception = (r_state == S_DONE) & r_exc;

endmodule
